interrupt_sequencer: RTL and testbench

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

---
 rtl/interrupt_sequencer_if.sv | 26 ++
 rtl/interrupt_sequencer.sv | 103 ++++++++++
 tb/tb_interrupt_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/interrupt_sequencer_if.sv
// Bus between the interrupt sequencer and the multicycle core: request and
// return inputs from the core, hold/strobe/vector outputs back to its controller.
interface interrupt_sequencer_if;
  logic        INT;
  logic        NMI;
  logic        INTD;
  logic        instrBoundary;
  logic        eret;
  logic        holdCtrl;
  logic        epcWrite;
  logic        pcVecWrite;
  logic [31:0] vectorAddr;
  logic        INA;
  logic [1:0]  inService;
  logic        isInterrupted;

  modport slave (
    input  INT, NMI, INTD, instrBoundary, eret,
    output holdCtrl, epcWrite, pcVecWrite, vectorAddr, INA, inService, isInterrupted
  );

  modport master (
    output INT, NMI, INTD, instrBoundary, eret,
    input  holdCtrl, epcWrite, pcVecWrite, vectorAddr, INA, inService, isInterrupted
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: at an instruction boundary it freezes the controller,
// saves the PC to EPC, then vectors to the NMI or INT handler and tracks nesting.
module interrupt_sequencer #(
  parameter logic [31:0] VEC_INT = 32'h0000_0040,
  parameter logic [31:0] VEC_NMI = 32'h0000_0080
) (
  input logic clk,
  input logic reset,
  interrupt_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SAVE, VECTOR} state_t;

  state_t      state;
  logic        nmi_q;
  logic        nmi_pending;
  logic        kind_nmi;
  logic [1:0]  in_service;
  logic        hold_ctrl;
  logic        epc_write;
  logic        pc_vec_write;
  logic        ina;

  logic        nmi_edge;
  logic [1:0]  in_service_upd;
  logic        nmi_ok;
  logic        int_ok;

  // A return retires the innermost service level before eligibility is judged,
  // so a boundary in the same cycle already sees the lowered nesting.
  always_comb begin
    nmi_edge       = bus.NMI & ~nmi_q;
    in_service_upd = in_service;
    if (state == IDLE && bus.eret) begin
      if (in_service[1])
        in_service_upd[1] = 1'b0;
      else if (in_service[0])
        in_service_upd[0] = 1'b0;
    end
    nmi_ok = nmi_pending & ~in_service_upd[1];
    int_ok = bus.INT & ~bus.INTD & ~in_service_upd[1] & ~in_service_upd[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      nmi_q        <= 1'b0;
      nmi_pending  <= 1'b0;
      kind_nmi     <= 1'b0;
      in_service   <= 2'b00;
      hold_ctrl    <= 1'b0;
      epc_write    <= 1'b0;
      pc_vec_write <= 1'b0;
      ina          <= 1'b0;
    end else begin
      nmi_q        <= bus.NMI;
      hold_ctrl    <= 1'b0;
      epc_write    <= 1'b0;
      pc_vec_write <= 1'b0;
      ina          <= 1'b0;

      // A fresh edge wins over the clear so a back-to-back NMI is never lost.
      if (nmi_edge)
        nmi_pending <= 1'b1;
      else if (state == SAVE && kind_nmi)
        nmi_pending <= 1'b0;

      case (state)
        IDLE: begin
          in_service <= in_service_upd;
          if (bus.instrBoundary && (nmi_ok || int_ok)) begin
            state     <= SAVE;
            kind_nmi  <= nmi_ok;
            epc_write <= 1'b1;
            hold_ctrl <= 1'b1;
          end
        end
        SAVE: begin
          state                <= VECTOR;
          pc_vec_write         <= 1'b1;
          hold_ctrl            <= 1'b1;
          ina                  <= ~kind_nmi;
          in_service[kind_nmi] <= 1'b1;
        end
        VECTOR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.holdCtrl      = hold_ctrl;
  assign bus.epcWrite      = epc_write;
  assign bus.pcVecWrite    = pc_vec_write;
  assign bus.INA           = ina;
  assign bus.vectorAddr    = kind_nmi ? VEC_NMI : VEC_INT;
  assign bus.inService     = in_service;
  assign bus.isInterrupted = |in_service;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: each step drives inputs, queues the
// outputs expected after the next clock edge and checks them from a scoreboard.
module tb_interrupt_sequencer;

  logic clk;
  logic reset;
  interrupt_sequencer_if bus ();

  interrupt_sequencer #(
    .VEC_INT(32'h0000_0040),
    .VEC_NMI(32'h0000_0080)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input selectors, OR-ed together: {reset, INT, NMI, INTD, instrBoundary, eret}
  localparam logic [5:0] R = 6'b100000;
  localparam logic [5:0] I = 6'b010000;
  localparam logic [5:0] N = 6'b001000;
  localparam logic [5:0] D = 6'b000100;
  localparam logic [5:0] B = 6'b000010;
  localparam logic [5:0] E = 6'b000001;
  localparam logic [5:0] Z = 6'b000000;

  // Strobe patterns {holdCtrl, epcWrite, pcVecWrite, INA}
  localparam logic [3:0] IDL  = 4'b0000;
  localparam logic [3:0] SAV  = 4'b1100;
  localparam logic [3:0] VINT = 4'b1011;
  localparam logic [3:0] VNMI = 4'b1010;

  localparam logic [31:0] A_INT = 32'h0000_0040;
  localparam logic [31:0] A_NMI = 32'h0000_0080;
  localparam logic [31:0] NOVEC = 32'h0000_0000;

  typedef struct {
    string       tag;
    logic [3:0]  strobes;
    logic [1:0]  svc;
    logic [31:0] vec;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput();
    exp_t        e;
    logic [6:0]  got;
    logic [6:0]  want;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty got 0 entries required 1");
      return;
    end
    e    = sb.pop_front();
    got  = {bus.holdCtrl, bus.epcWrite, bus.pcVecWrite, bus.INA, bus.inService, bus.isInterrupted};
    want = {e.strobes, e.svc, |e.svc};
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("[TB] FAIL %s outputs got %b required %b", e.tag, got, want);
    end
    if (e.vec != NOVEC) begin
      checks++;
      assert (bus.vectorAddr === e.vec)
      else begin
        errors++;
        $error("[TB] FAIL %s vectorAddr got %h required %h", e.tag, bus.vectorAddr, e.vec);
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [5:0] in_sel,
                               input logic [3:0] strobes, input logic [1:0] svc,
                               input logic [31:0] vec);
    exp_t e;
    reset             = in_sel[5];
    bus.INT           = in_sel[4];
    bus.NMI           = in_sel[3];
    bus.INTD          = in_sel[2];
    bus.instrBoundary = in_sel[1];
    bus.eret          = in_sel[0];
    e.tag     = tag;
    e.strobes = strobes;
    e.svc     = svc;
    e.vec     = vec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    reset = 1'b1;
    bus.INT = 1'b0; bus.NMI = 1'b0; bus.INTD = 1'b0;
    bus.instrBoundary = 1'b0; bus.eret = 1'b0;

    // Reset dominates active requests
    applyStimulus("reset_a", R | I | B, IDL, 2'b00, A_INT);
    applyStimulus("reset_b", R, IDL, 2'b00, A_INT);

    // Basic maskable entry and single-level nesting rules
    applyStimulus("int_save", I | B, SAV, 2'b00, NOVEC);
    applyStimulus("int_vector", I, VINT, 2'b01, A_INT);
    applyStimulus("int_resume", I, IDL, 2'b01, NOVEC);
    applyStimulus("int_no_reenter", I | B, IDL, 2'b01, NOVEC);
    applyStimulus("eret_int", E, IDL, 2'b00, NOVEC);
    applyStimulus("eret_idle_ignored", E, IDL, 2'b00, NOVEC);

    // Disabled INT never enters, then enters once enabled
    for (int k = 0; k < 10; k++)
      applyStimulus("intd_blocked", I | D | B, IDL, 2'b00, NOVEC);
    applyStimulus("intd_clear_save", I | B, SAV, 2'b00, NOVEC);
    applyStimulus("intd_clear_vector", I, VINT, 2'b01, A_INT);
    applyStimulus("intd_clear_idle", Z, IDL, 2'b01, NOVEC);
    applyStimulus("eret_after_intd", E, IDL, 2'b00, NOVEC);

    // INT is level-sensitive and not latched
    applyStimulus("int_pulse", I, IDL, 2'b00, NOVEC);
    applyStimulus("int_gone_boundary", B, IDL, 2'b00, NOVEC);

    // NMI beats a concurrent INT; INT waits for the NMI return
    applyStimulus("nmi_int_edge", I | N, IDL, 2'b00, NOVEC);
    applyStimulus("nmi_prio_save", I | N | B, SAV, 2'b00, NOVEC);
    applyStimulus("nmi_prio_vector", I | N | B, VNMI, 2'b10, A_NMI);
    applyStimulus("int_blocked_by_nmi", I | N | B, IDL, 2'b10, NOVEC);
    applyStimulus("eret_boundary_same", I | N | B | E, SAV, 2'b00, NOVEC);
    applyStimulus("int_after_nmi_vector", I, VINT, 2'b01, A_INT);
    applyStimulus("int_after_nmi_idle", Z, IDL, 2'b01, NOVEC);

    // NMI preempts an INT in service, then two returns unwind
    applyStimulus("nest_edge", N, IDL, 2'b01, NOVEC);
    applyStimulus("nest_save", N | B, SAV, 2'b01, NOVEC);
    applyStimulus("nest_vector", N, VNMI, 2'b11, A_NMI);
    applyStimulus("nest_idle", N | B, IDL, 2'b11, NOVEC);
    applyStimulus("nest_eret_nmi", N | E, IDL, 2'b01, NOVEC);
    applyStimulus("nest_eret_int", E, IDL, 2'b00, NOVEC);

    // NMI edge during an INT entry stays pending and is taken afterwards
    applyStimulus("late_int_save", I | B, SAV, 2'b00, NOVEC);
    applyStimulus("late_nmi_in_save", N | E, VINT, 2'b01, A_INT);
    applyStimulus("late_vector_done", N | B, IDL, 2'b01, NOVEC);
    applyStimulus("late_nmi_save", N | B, SAV, 2'b01, NOVEC);
    applyStimulus("late_nmi_vector", N, VNMI, 2'b11, A_NMI);
    applyStimulus("late_nmi_idle", Z, IDL, 2'b11, NOVEC);

    // Second NMI edge while NMI in service waits for its return
    applyStimulus("nmi_in_nmi_edge", N | B, IDL, 2'b11, NOVEC);
    applyStimulus("nmi_in_nmi_edge2", B, IDL, 2'b11, NOVEC);
    applyStimulus("nmi_in_nmi_edge3", N | B, IDL, 2'b11, NOVEC);
    applyStimulus("nmi_in_nmi_ret", E | B, SAV, 2'b01, NOVEC);
    applyStimulus("nmi_in_nmi_vector", Z, VNMI, 2'b11, A_NMI);
    applyStimulus("nmi_single_queue", B, IDL, 2'b11, NOVEC);
    applyStimulus("unwind_nmi", E | B, IDL, 2'b01, NOVEC);
    applyStimulus("unwind_int", E, IDL, 2'b00, NOVEC);

    // Reset aborts an INT entry in SAVE
    applyStimulus("abort_int_save", I | B, SAV, 2'b00, NOVEC);
    applyStimulus("abort_int_reset", R | I, IDL, 2'b00, A_INT);
    applyStimulus("abort_int_after", Z, IDL, 2'b00, NOVEC);

    // Reset aborts an NMI entry and drops the pending NMI
    applyStimulus("abort_nmi_edge", N, IDL, 2'b00, NOVEC);
    applyStimulus("abort_nmi_save", N | B, SAV, 2'b00, NOVEC);
    applyStimulus("abort_nmi_reset", R, IDL, 2'b00, A_INT);
    applyStimulus("abort_nmi_dropped", B, IDL, 2'b00, NOVEC);

    // NMI held high across reset release counts as one edge
    applyStimulus("nmi_hold_reset", R | N, IDL, 2'b00, A_INT);
    applyStimulus("nmi_hold_release", N, IDL, 2'b00, NOVEC);
    applyStimulus("nmi_hold_save", N | B, SAV, 2'b00, NOVEC);
    applyStimulus("nmi_hold_vector", N | B, VNMI, 2'b10, A_NMI);
    applyStimulus("nmi_hold_idle", N | B, IDL, 2'b10, NOVEC);
    applyStimulus("nmi_hold_eret", E, IDL, 2'b00, NOVEC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
